exp7_unidade_controle: RTL and testbench

Moore control unit for the exp7 memory-game datapath (exp7_fluxo_dados). It sequences the address, round, timeout and LED counters, the play register, the RAM write and the LED muxes. Each round is played in four phases: replay the stored sequence on the LEDs, check the player's plays, append one new play to RAM, advance the round. It sits beside the datapath inside the exp7 top level; all its outputs are datapath control strobes or status/debug lines.

---
 rtl/exp7_unidade_controle.sv | 193 +++++++++++++++++++
 tb/tb_exp7_unidade_controle.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exp7_unidade_controle.sv
// exp7_unidade_controle -- Moore control unit for the exp7 memory game.
// Sequences replay, play checking, RAM append and round advance over the
// exp7_fluxo_dados datapath. All controls are decoded from the state register.
// Optional feature: define UC_TIMEOUT_EN to make the play wait states honour
// the timeout input (loss with db_timeout=1). Without it the waits ignore
// timeout, although contaT is still asserted while waiting.
module exp7_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  input  logic       halfsec_reach,
  input  logic       twosec_reach,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       contaT,
  output logic       contaL,
  output logic       led_selector,
  output logic       led_turn_off,
  output logic       ram_enable,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [4:0] db_estado
);

`ifdef UC_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  typedef enum logic [4:0] {
    INICIAL          = 5'h00,
    PREPARACAO       = 5'h01,
    INICIO_RODADA    = 5'h02,
    MOSTRA_LED       = 5'h03,
    APAGA_LED        = 5'h04,
    PROXIMO_LED      = 5'h05,
    FIM_EXIBICAO     = 5'h06,
    ESPERA_JOGADA    = 5'h07,
    REGISTRA         = 5'h08,
    COMPARA          = 5'h09,
    PROXIMA_JOGADA   = 5'h0A,
    PROXIMA_ESCRITA  = 5'h0B,
    ESPERA_ESCRITA   = 5'h0C,
    REGISTRA_ESCRITA = 5'h0D,
    ESCREVE          = 5'h0E,
    PROXIMA_RODADA   = 5'h0F,
    GANHOU           = 5'h10,
    PERDEU           = 5'h11
  } estado_t;

  estado_t state_q, state_d;
  logic    db_timeout_q, db_timeout_d;

  // A timeout only counts when the feature is built in and no play arrived
  // in the same cycle (a play always wins the race).
  logic tmo_hit;
  assign tmo_hit = TMO_EN & timeout & ~jogada_feita;

  // State and timeout-cause flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= INICIAL;
      db_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_timeout_q <= db_timeout_d;
    end
  end

  // Next-state selection; unused codes fall back to inicial.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL, GANHOU, PERDEU: if (iniciar) state_d = PREPARACAO;
      PREPARACAO:    state_d = INICIO_RODADA;
      INICIO_RODADA: state_d = MOSTRA_LED;
      MOSTRA_LED:
        if (twosec_reach) state_d = enderecoIgualRodada ? FIM_EXIBICAO : APAGA_LED;
      APAGA_LED:     if (halfsec_reach) state_d = PROXIMO_LED;
      PROXIMO_LED:   state_d = MOSTRA_LED;
      FIM_EXIBICAO:  state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita) state_d = REGISTRA;
        else if (tmo_hit) state_d = PERDEU;
      end
      REGISTRA:      state_d = COMPARA;
      COMPARA: begin
        if (!jogada_correta)           state_d = PERDEU;
        else if (!enderecoIgualRodada) state_d = PROXIMA_JOGADA;
        else if (fimL)                 state_d = GANHOU;
        else                           state_d = PROXIMA_ESCRITA;
      end
      PROXIMA_JOGADA:  state_d = ESPERA_JOGADA;
      PROXIMA_ESCRITA: state_d = ESPERA_ESCRITA;
      ESPERA_ESCRITA: begin
        if (jogada_feita) state_d = REGISTRA_ESCRITA;
        else if (tmo_hit) state_d = PERDEU;
      end
      REGISTRA_ESCRITA: state_d = ESCREVE;
      ESCREVE:          state_d = PROXIMA_RODADA;
      PROXIMA_RODADA:   state_d = INICIO_RODADA;
      default:          state_d = INICIAL;
    endcase
  end

  // Timeout flag: set on a timeout-driven entry into perdeu, cleared as a
  // new game enters preparacao.
  always_comb begin
    db_timeout_d = db_timeout_q;
    if (state_d == PREPARACAO)
      db_timeout_d = 1'b0;
    else if ((state_q == ESPERA_JOGADA || state_q == ESPERA_ESCRITA) && tmo_hit)
      db_timeout_d = 1'b1;
  end

  // Moore output decode.
  always_comb begin
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    contaT       = 1'b0;
    contaL       = 1'b0;
    led_selector = 1'b0;
    led_turn_off = 1'b0;
    ram_enable   = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
      end
      INICIO_RODADA: zeraE = 1'b1;
      MOSTRA_LED: begin
        led_selector = 1'b1;
        registraLeds = 1'b1;
        contaL       = 1'b1;
      end
      APAGA_LED: begin
        led_turn_off = 1'b1;
        contaL       = 1'b1;
      end
      PROXIMO_LED: contaE = 1'b1;
      FIM_EXIBICAO: begin
        zeraE    = 1'b1;
        zeraLeds = 1'b1;
      end
      ESPERA_JOGADA, ESPERA_ESCRITA: contaT = 1'b1;
      REGISTRA, REGISTRA_ESCRITA:    registraRC = 1'b1;
      PROXIMA_JOGADA, PROXIMA_ESCRITA: begin
        contaE  = 1'b1;
        limpaRC = 1'b1;
      end
      ESCREVE:        ram_enable = 1'b1;
      PROXIMA_RODADA: contaCR = 1'b1;
      GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_timeout = db_timeout_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for exp7_unidade_controle: plays randomized games, acting as the
// datapath, and checks state code, all controls and db_timeout every cycle.
module tb_exp7_unidade_controle;

`ifdef UC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
  logic fimL, timeout, halfsec_reach, twosec_reach;
  logic zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds;
  logic registraLeds, contaT, contaL, led_selector, led_turn_off, ram_enable;
  logic pronto, ganhou, perdeu, db_timeout;
  logic [4:0] db_estado;

  exp7_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada), .fimL(fimL),
    .timeout(timeout), .halfsec_reach(halfsec_reach), .twosec_reach(twosec_reach),
    .zeraCR(zeraCR), .zeraE(zeraE), .contaCR(contaCR), .contaE(contaE),
    .limpaRC(limpaRC), .registraRC(registraRC), .zeraLeds(zeraLeds),
    .registraLeds(registraLeds), .contaT(contaT), .contaL(contaL),
    .led_selector(led_selector), .led_turn_off(led_turn_off),
    .ram_enable(ram_enable), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit exp_tmo = 1'b0;

  // Output table taken straight from the state/output list.
  logic [15:0] exp_out [0:31];
  logic [15:0] outs;
  assign outs = {zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds,
                 registraLeds, contaT, contaL, led_selector, led_turn_off,
                 ram_enable, pronto, ganhou, perdeu};

  localparam int B_ZCR = 15, B_ZE = 14, B_CCR = 13, B_CE = 12, B_LRC = 11,
                 B_RRC = 10, B_ZL = 9, B_RL = 8, B_CT = 7, B_CL = 6, B_LS = 5,
                 B_LT = 4, B_RAM = 3, B_PR = 2, B_G = 1, B_P = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_in();
    jogada_feita = 0; jogada_correta = 0; enderecoIgualRodada = 0; fimL = 0;
    timeout = 0; halfsec_reach = 0; twosec_reach = 0;
  endtask

  // One clock edge, then compare everything against the expected state.
  task automatic step(input logic [4:0] st, input string tag);
    @(posedge clock); #1;
    chk({tag, "/estado"}, 32'(db_estado), 32'(st));
    chk({tag, "/outs"}, 32'(outs), 32'(exp_out[st]));
    chk({tag, "/db_timeout"}, 32'(db_timeout), 32'(exp_tmo));
  endtask

  task automatic hold_end(input logic [4:0] st);
    clr_in(); iniciar = 0;
    repeat (3) step(st, "fim_hold");
  endtask

  // kind: 0 win, 1 wrong play at (lose_rnd, lose_addr),
  //       2 timeout in espera_jogada at (lose_rnd, lose_addr),
  //       3 timeout in espera_escrita at lose_rnd.
  task automatic play_game(input int kind, input int lose_rnd, input int lose_addr);
    bit wrong;
    clr_in();
    iniciar = 1; exp_tmo = 0;
    step(5'h01, "preparacao");
    iniciar = 0;
    step(5'h02, "inicio_rodada");
    for (int r = 0; r < 16; r++) begin
      // replay of addresses 0..r
      for (int a = 0; a <= r; a++) begin
        clr_in();
        step(5'h03, "mostra_led");
        repeat ($urandom_range(0, 2)) step(5'h03, "mostra_hold");
        twosec_reach = 1; enderecoIgualRodada = (a == r);
        if (a == r) step(5'h06, "fim_exibicao");
        else begin
          step(5'h04, "apaga_led");
          clr_in();
          repeat ($urandom_range(0, 2)) step(5'h04, "apaga_hold");
          halfsec_reach = 1;
          step(5'h05, "proximo_led");
        end
      end
      clr_in();
      step(5'h07, "espera_jogada");
      // plays of addresses 0..r
      for (int a = 0; a <= r; a++) begin
        clr_in();
        repeat ($urandom_range(0, 2)) step(5'h07, "espera_hold");
        if (kind == 2 && r == lose_rnd && a == lose_addr) begin
          timeout = 1;
          if (TMO_EN) begin
            exp_tmo = 1;
            step(5'h11, "timeout_jogada");
            hold_end(5'h11);
            return;
          end
          repeat (10000) step(5'h07, "timeout_ignorado");
        end
        jogada_feita = 1; timeout = 1'($urandom_range(0, 1));
        step(5'h08, "registra");
        clr_in();
        step(5'h09, "compara");
        wrong = (kind == 1 && r == lose_rnd && a == lose_addr);
        jogada_correta = !wrong; enderecoIgualRodada = (a == r); fimL = (r == 15);
        if (wrong) begin
          step(5'h11, "perdeu");
          hold_end(5'h11);
          return;
        end else if (a < r) begin
          step(5'h0A, "proxima_jogada");
          clr_in();
          step(5'h07, "espera_jogada");
        end else if (r == 15) begin
          step(5'h10, "ganhou");
          hold_end(5'h10);
          return;
        end else begin
          step(5'h0B, "proxima_escrita");
          clr_in();
          step(5'h0C, "espera_escrita");
          repeat ($urandom_range(0, 2)) step(5'h0C, "escrita_hold");
          if (kind == 3 && r == lose_rnd) begin
            timeout = 1;
            if (TMO_EN) begin
              exp_tmo = 1;
              step(5'h11, "timeout_escrita");
              hold_end(5'h11);
              return;
            end
            repeat (3) step(5'h0C, "timeout_escrita_ignorado");
          end
          jogada_feita = 1; timeout = 1'($urandom_range(0, 1));
          step(5'h0D, "registra_escrita");
          clr_in();
          step(5'h0E, "escreve");
          step(5'h0F, "proxima_rodada");
          step(5'h02, "inicio_rodada");
        end
      end
    end
    chk("game_escape", 32'd1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_out[i] = '0;
    exp_out[5'h01] = (16'd1 << B_ZCR) | (16'd1 << B_ZE) | (16'd1 << B_LRC) | (16'd1 << B_ZL);
    exp_out[5'h02] = (16'd1 << B_ZE);
    exp_out[5'h03] = (16'd1 << B_LS) | (16'd1 << B_RL) | (16'd1 << B_CL);
    exp_out[5'h04] = (16'd1 << B_LT) | (16'd1 << B_CL);
    exp_out[5'h05] = (16'd1 << B_CE);
    exp_out[5'h06] = (16'd1 << B_ZE) | (16'd1 << B_ZL);
    exp_out[5'h07] = (16'd1 << B_CT);
    exp_out[5'h08] = (16'd1 << B_RRC);
    exp_out[5'h0A] = (16'd1 << B_CE) | (16'd1 << B_LRC);
    exp_out[5'h0B] = (16'd1 << B_CE) | (16'd1 << B_LRC);
    exp_out[5'h0C] = (16'd1 << B_CT);
    exp_out[5'h0D] = (16'd1 << B_RRC);
    exp_out[5'h0E] = (16'd1 << B_RAM);
    exp_out[5'h0F] = (16'd1 << B_CCR);
    exp_out[5'h10] = (16'd1 << B_PR) | (16'd1 << B_G);
    exp_out[5'h11] = (16'd1 << B_PR) | (16'd1 << B_P);

    reset = 0; iniciar = 0; clr_in();
    repeat (2) @(posedge clock);
    #1;
    chk("reset/estado", 32'(db_estado), 32'h00);
    chk("reset/outs", 32'(outs), 32'h0);
    chk("reset/db_timeout", 32'(db_timeout), 32'h0);
    reset = 1;
    step(5'h00, "inicial_idle");

    // Reset asserted in the middle of mostra_led takes effect immediately.
    iniciar = 1;
    step(5'h01, "rst_prep");
    iniciar = 0;
    step(5'h02, "rst_ini");
    step(5'h03, "rst_mostra");
    step(5'h03, "rst_mostra2");
    #2 reset = 0; #1;
    chk("async_reset/estado", 32'(db_estado), 32'h00);
    chk("async_reset/outs", 32'(outs), 32'h0);
    exp_tmo = 0;
    iniciar = 1;
    step(5'h00, "reset_held");
    reset = 1;
    step(5'h01, "post_rst_prep");
    iniciar = 0;
    step(5'h02, "post_rst_ini");
    twosec_reach = 1; enderecoIgualRodada = 1;
    step(5'h03, "post_rst_mostra");
    step(5'h06, "post_rst_fim_exib");
    clr_in();
    step(5'h07, "post_rst_espera");
    timeout = 1;
    if (TMO_EN) begin
      exp_tmo = 1;
      step(5'h11, "first_timeout");
      hold_end(5'h11);
    end else begin
      step(5'h07, "first_timeout_ignored");
      clr_in();
      jogada_feita = 1; step(5'h08, "ft_registra");
      clr_in(); step(5'h09, "ft_compara");
      jogada_correta = 0; enderecoIgualRodada = 1;
      step(5'h11, "ft_wrong");
      hold_end(5'h11);
    end

    // Randomized games.
    begin
      int lr;
      lr = $urandom_range(0, 5);
      play_game(1, lr, $urandom_range(0, lr));
      lr = $urandom_range(0, 3);
      play_game(2, lr, $urandom_range(0, lr));
      play_game(3, $urandom_range(0, 4), 0);
      play_game(0, 0, 0);
      play_game(1, 15, 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
